// File: rtl/l2_mem_rr_scheduler_if.sv
// Bundle of the L2-requester and main-memory signals of l2_mem_rr_scheduler.
// slave  : the scheduler's view (serves requesters, drives the memory port).
// master : the environment's view (requesters plus memory).
interface l2_mem_rr_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4
);
  localparam int unsigned ID_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS-1:0]                 req_write;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]                 req_ready;
  logic [NUM_PORTS-1:0]                 resp_valid;
  logic [DATA_WIDTH-1:0]                resp_rdata;
  logic                                 resp_err;
  logic [ID_W-1:0]                      grant_id;
  logic                                 busy;
  logic [ADDR_WIDTH-1:0]                mem_address;
  logic [DATA_WIDTH-1:0]                mem_write_data;
  logic                                 mem_read_req;
  logic                                 mem_write_req;
  logic [DATA_WIDTH-1:0]                mem_read_data;
  logic                                 mem_ready;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, grant_id, busy,
           mem_address, mem_write_data, mem_read_req, mem_write_req
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, grant_id, busy,
           mem_address, mem_write_data, mem_read_req, mem_write_req
  );
endinterface

// File: rtl/l2_mem_rr_scheduler.sv
// Round-robin scheduler sharing one main-memory port among NUM_PORTS L2
// requesters. One transaction at a time: IDLE (arbitrate + latch) -> WAIT
// (hold memory request until mem_ready) -> RESP (rotate priority) -> IDLE.
// Optional memory watchdog enabled by defining MEM_TIMEOUT_EN; without it
// WAIT never times out and resp_err is constant 0.
module l2_mem_rr_scheduler #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                   clk,
  input logic                   reset_n,
  l2_mem_rr_scheduler_if.slave  bus
);
  localparam int unsigned ID_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic                  mem_read_req_q, mem_read_req_d;
  logic                  mem_write_req_q, mem_write_req_d;
  logic [NUM_PORTS-1:0]  req_ready_q, req_ready_d;
  logic [NUM_PORTS-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  busy_q, busy_d;

  logic                  sel_found;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       cand;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  resp_err_q, resp_err_d;
  logic                  tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  // Arbiter: first pending port scanning upward from rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % NUM_PORTS);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    grant_id_d       = grant_id_q;
    op_write_d       = op_write_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_read_req_d   = mem_read_req_q;
    mem_write_req_d  = mem_write_req_q;
    req_ready_d      = '0;
    resp_valid_d     = '0;
    resp_rdata_d     = resp_rdata_q;
    busy_d           = busy_q;
`ifdef MEM_TIMEOUT_EN
    tmo_cnt_d        = tmo_cnt_q;
    resp_err_d       = resp_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_id_d          = sel_id;
          op_write_d          = bus.req_write[sel_id];
          mem_address_d       = bus.req_addr[sel_id];
          mem_write_data_d    = bus.req_wdata[sel_id];
          mem_read_req_d      = ~bus.req_write[sel_id];
          mem_write_req_d     = bus.req_write[sel_id];
          req_ready_d[sel_id] = 1'b1;
          busy_d              = 1'b1;
          state_d             = S_WAIT;
`ifdef MEM_TIMEOUT_EN
          tmo_cnt_d           = '0;
`endif
        end
      end

      S_WAIT: begin
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        if (bus.mem_ready) begin
          mem_read_req_d           = 1'b0;
          mem_write_req_d          = 1'b0;
          resp_rdata_d             = op_write_q ? '0 : bus.mem_read_data;
          resp_valid_d[grant_id_q] = 1'b1;
          state_d                  = S_RESP;
`ifdef MEM_TIMEOUT_EN
          resp_err_d               = 1'b0;
        end else if (tmo_hit) begin
          mem_read_req_d           = 1'b0;
          mem_write_req_d          = 1'b0;
          resp_rdata_d             = '0;
          resp_valid_d[grant_id_q] = 1'b1;
          resp_err_d               = 1'b1;
          state_d                  = S_RESP;
`endif
        end
      end

      S_RESP: begin
        rr_ptr_d = (grant_id_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id_q + ID_W'(1);
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      rr_ptr_q         <= '0;
      grant_id_q       <= '0;
      op_write_q       <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_req_q   <= 1'b0;
      mem_write_req_q  <= 1'b0;
      req_ready_q      <= '0;
      resp_valid_q     <= '0;
      resp_rdata_q     <= '0;
      busy_q           <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      resp_err_q       <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      grant_id_q       <= grant_id_d;
      op_write_q       <= op_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_read_req_q   <= mem_read_req_d;
      mem_write_req_q  <= mem_write_req_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_rdata_q     <= resp_rdata_d;
      busy_q           <= busy_d;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q        <= tmo_cnt_d;
      resp_err_q       <= resp_err_d;
`endif
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.grant_id       = grant_id_q;
  assign bus.busy           = busy_q;
  assign bus.mem_address    = mem_address_q;
  assign bus.mem_write_data = mem_write_data_q;
  assign bus.mem_read_req   = mem_read_req_q;
  assign bus.mem_write_req  = mem_write_req_q;
`ifdef MEM_TIMEOUT_EN
  assign bus.resp_err       = resp_err_q;
`else
  assign bus.resp_err       = 1'b0;
`endif
endmodule

// File: tb/tb_l2_mem_rr_scheduler.sv
// Self-checking bench for l2_mem_rr_scheduler: directed scenarios followed by
// randomized request arrivals and memory latencies, compared against a
// behavioural model of pending requests and rotating priority.
module tb_l2_mem_rr_scheduler;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NP = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TB_TMO = 8;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  logic clk;
  logic reset_n;

  l2_mem_rr_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  l2_mem_rr_scheduler #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_PORTS(NP),
    .TIMEOUT_CYCLES(TB_TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [NP-1:0] pend;
  bit            m_wr[NP];
  logic [AW-1:0] m_addr[NP];
  logic [DW-1:0] m_wdata[NP];
  int unsigned   rr;
  bit            rand_mode;

  int unsigned n_checks;
  int unsigned n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Priority winner: pending port with the smallest forward distance from rr.
  function automatic int unsigned exp_grant();
    int unsigned best;
    int unsigned bestd;
    best  = 0;
    bestd = NP;
    for (int unsigned p = 0; p < NP; p++) begin
      if (pend[p] && ((p + NP - rr) % NP) < bestd) begin
        bestd = (p + NP - rr) % NP;
        best  = p;
      end
    end
    return best;
  endfunction

  task automatic raise(input int unsigned p, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    m_wr[p]            = wr;
    m_addr[p]          = a;
    m_wdata[p]         = d;
    pend[p]            = 1'b1;
    bus.req_write[p]   = wr;
    bus.req_addr[p]    = a;
    bus.req_wdata[p]   = d;
    bus.req_valid[p]   = 1'b1;
  endtask

  task automatic maybe_arrive();
    if (rand_mode) begin
      for (int unsigned p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 3) == 0)
          raise(p, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
  endtask

  // One full transaction for the currently pending set; delay = WAIT cycles
  // until the mem_ready edge, or tmo = 1 to let the watchdog fire instead.
  task automatic run_txn(input int unsigned delay, input logic [DW-1:0] rd, input bit tmo);
    int unsigned   g;
    int unsigned   lat;
    int unsigned   n_wait;
    bit            ewr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [DW-1:0] erd;
    g   = exp_grant();
    ewr = m_wr[g];
    ea  = m_addr[g];
    ed  = m_wdata[g];
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.req_ready == '0 && lat < 8);
    chk("accept_latency", 64'(lat), 64'd1);
    chk("req_ready", 64'(bus.req_ready), 64'(1 << g));
    chk("grant_id", 64'(bus.grant_id), 64'(g));
    chk("busy_wait", 64'(bus.busy), 64'd1);
    chk("mem_req", {bus.mem_read_req, bus.mem_write_req}, {!ewr, ewr});
    chk("mem_address", 64'(bus.mem_address), 64'(ea));
    chk("mem_write_data", 64'(bus.mem_write_data), 64'(ed));
    bus.req_valid[g] = 1'b0;
    pend[g]          = 1'b0;
    n_wait = tmo ? TB_TMO : delay;
    for (int unsigned j = 1; j < n_wait; j++) begin
      @(posedge clk); #1;
      chk("mem_req_hold", {bus.mem_read_req, bus.mem_write_req}, {!ewr, ewr});
      chk("addr_hold", 64'(bus.mem_address), 64'(ea));
      chk("no_early_resp", 64'({bus.resp_valid, bus.req_ready}), 64'd0);
      maybe_arrive();
    end
    if (!tmo) begin
      bus.mem_ready     = 1'b1;
      bus.mem_read_data = rd;
    end
    @(posedge clk); #1;
    bus.mem_ready     = 1'($urandom_range(0, 1));
    bus.mem_read_data = $urandom;
    erd = (tmo || ewr) ? '0 : rd;
    chk("resp_valid", 64'(bus.resp_valid), 64'(1 << g));
    chk("resp_rdata", 64'(bus.resp_rdata), 64'(erd));
    chk("resp_err", 64'(bus.resp_err), 64'(tmo));
    chk("mem_req_drop", {bus.mem_read_req, bus.mem_write_req}, 2'b00);
    rr = (g + 1) % NP;
    maybe_arrive();
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    chk("resp_pulse_end", 64'({bus.resp_valid, bus.busy}), 64'd0);
    chk("resp_rdata_hold", 64'(bus.resp_rdata), 64'(erd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rand_mode = 1'b0;
    pend = '0;
    rr   = 0;
    for (int unsigned p = 0; p < NP; p++) begin
      m_wr[p] = 1'b0; m_addr[p] = '0; m_wdata[p] = '0;
    end
    reset_n           = 1'b0;
    bus.req_valid     = '0;
    bus.req_write     = '0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_read_data = '0;
    bus.mem_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_resp", 64'({bus.req_ready, bus.resp_valid}), 64'd0);
    chk("rst_misc", 64'({bus.resp_err, bus.grant_id, bus.busy, bus.mem_read_req, bus.mem_write_req}), 64'd0);
    chk("rst_data", {bus.mem_address, bus.resp_rdata}, 64'd0);
    chk("rst_wdata", 64'(bus.mem_write_data), 64'd0);
    reset_n = 1'b1;

    // All four ports at once, immediate memory: grants 0,1,2,3 back to back.
    for (int unsigned p = 0; p < NP; p++) raise(p, 1'b0, 32'h1000 + 32'(p * 4), '0);
    for (int unsigned k = 0; k < NP; k++) run_txn(1, $urandom, 1'b0);

    // Port 3 alone, then 0 and 3 together: wrap puts port 0 first.
    raise(3, 1'b0, 32'h300, '0);
    run_txn(2, 32'hA5A5_0003, 1'b0);
    raise(0, 1'b0, 32'h000, '0);
    raise(3, 1'b1, 32'h304, 32'hCAFE_0003);
    run_txn(1, 32'h0000_0BAD, 1'b0);
    run_txn(1, 32'h0000_0BAD, 1'b0);

    // Single read from port 2 with a 3-cycle memory delay.
    raise(2, 1'b0, 32'h100, '0);
    run_txn(3, 32'hDEAD_BEEF, 1'b0);

    // Write from port 1.
    raise(1, 1'b1, 32'h40, 32'h1234_5678);
    run_txn(2, 32'hFFFF_FFFF, 1'b0);

    // Reset while waiting on memory: nothing completes, priority restarts at 0.
    raise(2, 1'b0, 32'h200, '0);
    @(posedge clk); #1;
    chk("pre_rst_ready", 64'(bus.req_ready), 64'h4);
    bus.req_valid[2] = 1'b0;
    pend[2]          = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rr = 0;
    chk("midrst_outs", 64'({bus.req_ready, bus.resp_valid, bus.busy, bus.grant_id,
                            bus.mem_read_req, bus.mem_write_req}), 64'd0);
    chk("midrst_addr", 64'(bus.mem_address), 64'd0);
    @(posedge clk); #1;
    chk("midrst_no_resp", 64'({bus.resp_valid, bus.mem_read_req}), 64'd0);
    raise(3, 1'b0, 32'h330, '0);
    raise(2, 1'b0, 32'h220, '0);
    run_txn(1, 32'h2222_2222, 1'b0);
    run_txn(1, 32'h3333_3333, 1'b0);

`ifdef MEM_TIMEOUT_EN
    raise(1, 1'b0, 32'h110, '0);
    run_txn(0, '0, 1'b1);
    raise(1, 1'b0, 32'h114, '0);
    run_txn(1, 32'h7777_1111, 1'b0);
`endif

    // Randomized arrivals and memory latencies.
    rand_mode = 1'b1;
    for (int unsigned it = 0; it < 80; it++) begin
      if (pend == '0) begin
        @(posedge clk); #1;
        maybe_arrive();
      end else begin
        run_txn($urandom_range(1, 4), $urandom, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/l2_mem_rr_scheduler.md
# l2_mem_rr_scheduler

Round-robin scheduler that shares the single main-memory port among NUM_PORTS L2 cache requesters. It accepts one request at a time through a per-port valid/ready handshake and latches its address, data and opcode. It then drives the memory request lines until memory acknowledges and returns a one-cycle response pulse to the granted port. Grant priority rotates so that no L2 port is starved.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data word width
- NUM_PORTS, 4, number of L2 requesters (≥2)
- TIMEOUT_CYCLES, 255, memory watchdog limit; used only with MEM_TIMEOUT_EN
- clk  in  1  single clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_PORTS  per-port request pending
- req_write  in  NUM_PORTS  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH x NUM_PORTS  request address per port
- req_wdata  in  DATA_WIDTH x NUM_PORTS  write data per port
- req_ready  out  NUM_PORTS  one-cycle accept pulse, one-hot
- resp_valid  out  NUM_PORTS  one-cycle completion pulse, one-hot
- resp_rdata  out  DATA_WIDTH  read data, valid with resp_valid
- resp_err  out  1  timeout flag, valid with resp_valid
- grant_id  out  $clog2(NUM_PORTS)  port currently being served
- busy  out  1  high in WAIT and RESP
- mem_address  out  ADDR_WIDTH  memory address
- mem_write_data  out  DATA_WIDTH  memory write data
- mem_read_req  out  1  memory read request, level
- mem_write_req  out  1  memory write request, level
- mem_read_data  in  DATA_WIDTH  memory read data
- mem_ready  in  1  memory completion strobe

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- All outputs are registered. Reset value of every output is 0. The rotation pointer rr_ptr resets to 0.
- IDLE:
  - If any req_valid is high, select the first set bit scanning from rr_ptr upward, modulo NUM_PORTS.
  - Latch addr, wdata, write and id into mem_address, mem_write_data, the op register and grant_id.
  - Set req_ready[id]=1 and mem_read_req or mem_write_req =1, then go to WAIT.
- WAIT:
  - Hold the mem request and mem_address/mem_write_data stable.
  - On a sampled mem_ready=1: clear the mem request; resp_rdata <= mem_read_data for a read, 0 for a write; resp_valid[id]=1; go to RESP.
- RESP:
  - Set rr_ptr <= (id+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0. Go to IDLE.
- req_ready and resp_valid are single-cycle pulses.
- resp_rdata and resp_err hold their values until the next response.
- req_valid is ignored outside IDLE. A requester holds its fields stable until it sees req_ready and drops req_valid on the next edge.
- mem_ready is ignored in IDLE and RESP.
- Simultaneous requests: exactly one grant per acceptance. The others stay pending with no loss.
- Reset asserted mid-transaction: the transaction is abandoned. No response is issued, and the mem request drops in the next cycle.

## Timing
- Edge E0 in IDLE with a valid request: req_ready and the mem request are high in cycle E0+1.
- First mem_ready sampled at edge Ek (k≥1): resp_valid is high in cycle Ek+1, and the FSM is in IDLE after Ek+1.
- Minimum turnaround is 3 cycles per transaction. The earliest next acceptance is edge Ek+2.
- The mem request stays asserted from E0+1 through Ek inclusive.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A cycle counter is active in WAIT.
  - If mem_ready has not arrived after TIMEOUT_CYCLES WAIT cycles: drop the mem request, resp_valid[id]=1, resp_err=1, resp_rdata=0, go to RESP.
  - resp_err is 0 on normal completion. The counter clears on entry to WAIT.
- MEM_TIMEOUT_EN undefined: WAIT lasts indefinitely, resp_err is tied to 0, and no counter is synthesized.

## Test plan
- Single read, port 2, addr 0x100, memory returns 0xDEADBEEF with a 3-cycle delay -> req_ready=0b0100, mem_read_req high for 3 cycles, resp_valid=0b0100, resp_rdata=0xDEADBEEF.
- All four ports request reads together -> grants in order 0, 1, 2, 3. Each resp_valid is one-hot, with one transaction per 3 cycles when mem_ready is immediate.
- Port 3 served, then ports 0 and 3 both request -> port 0 wins (rr_ptr wrapped to 0), then port 3.
- Write from port 1, addr 0x40, data 0x12345678 -> mem_write_req=1 with mem_address=0x40 and mem_write_data=0x12345678, resp_valid=0b0010, resp_rdata=0.
- reset_n low for 1 cycle while in WAIT -> all outputs 0 next cycle and no resp_valid. A request from port 2 afterwards is granted first.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ready held at 0 -> after 8 WAIT cycles, resp_valid pulses with resp_err=1 and the mem request drops.
